motor_command_executor: RTL and testbench

//  Actuator-side counterpart of the sensor FSM. Consumes its command levels
//  (avancar, girar, remover) and executes each one as a timed motor/arm action.

---
 rtl/motor_command_executor.sv | 146 ++++++++++++++
 tb/tb_motor_command_executor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motor_command_executor.sv
// Executes avancar/girar/remover command levels as timed wheel/arm actions, tracks heading and, with ODOMETRY_EN, grid position.
// A command sampled at edge k drives its actuators for cycles k+1..k+N; commands arriving while busy are dropped, never queued.
module motor_command_executor #(
  parameter int FWD_CYCLES    = 8,
  parameter int TURN_CYCLES   = 12,
  parameter int REMOVE_CYCLES = 20,
  parameter int CNT_W         = 8,
  parameter int POS_W         = 8
) (
  input  logic             clockc2,
  input  logic             reset,
  input  logic             avancar,
  input  logic             girar,
  input  logic             remover,
  output logic             motor_esq,
  output logic             motor_dir,
  output logic             motor_dir_rev,
  output logic             braco,
  output logic             busy,
  output logic             done,
  output logic             erro,
  output logic [1:0]       heading,
  output logic [POS_W-1:0] pos_x,
  output logic [POS_W-1:0] pos_y
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FORWARD = 2'd1,
    TURN    = 2'd2,
    REMOVE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] FWD_LOAD  = CNT_W'(FWD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
  localparam logic [CNT_W-1:0] REM_LOAD  = CNT_W'(REMOVE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             motor_esq_q;
  logic             motor_dir_q;
  logic             motor_dir_rev_q;
  logic             braco_q;
  logic             busy_q;
  logic             done_q;
  logic             erro_q;
  logic [1:0]       heading_q;
  logic             multi_cmd;

  assign multi_cmd = (avancar & girar) | (avancar & remover) | (girar & remover);

  always_ff @(posedge clockc2 or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      motor_esq_q     <= 1'b0;
      motor_dir_q     <= 1'b0;
      motor_dir_rev_q <= 1'b0;
      braco_q         <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      erro_q          <= 1'b0;
      heading_q       <= 2'd0;
    end else begin
      done_q <= 1'b0;
      erro_q <= 1'b0;
      if (state_q == IDLE) begin
        erro_q <= multi_cmd;
        // Priority remover > girar > avancar; losers are simply dropped.
        if (remover) begin
          state_q <= REMOVE;
          cnt_q   <= REM_LOAD;
          busy_q  <= 1'b1;
          braco_q <= 1'b1;
        end else if (girar) begin
          state_q         <= TURN;
          cnt_q           <= TURN_LOAD;
          busy_q          <= 1'b1;
          motor_esq_q     <= 1'b1;
          motor_dir_rev_q <= 1'b1;
        end else if (avancar) begin
          state_q     <= FORWARD;
          cnt_q       <= FWD_LOAD;
          busy_q      <= 1'b1;
          motor_esq_q <= 1'b1;
          motor_dir_q <= 1'b1;
        end
      end else if (cnt_q == '0) begin
        state_q         <= IDLE;
        busy_q          <= 1'b0;
        done_q          <= 1'b1;
        motor_esq_q     <= 1'b0;
        motor_dir_q     <= 1'b0;
        motor_dir_rev_q <= 1'b0;
        braco_q         <= 1'b0;
        if (state_q == TURN) begin
          heading_q <= heading_q + 2'd1;
        end
      end else begin
        cnt_q <= cnt_q - CNT_ONE;
      end
    end
  end

  assign motor_esq     = motor_esq_q;
  assign motor_dir     = motor_dir_q;
  assign motor_dir_rev = motor_dir_rev_q;
  assign braco         = braco_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign erro          = erro_q;
  assign heading       = heading_q;

`ifdef ODOMETRY_EN
  localparam logic [POS_W-1:0] POS_ONE = POS_W'(1);

  logic [POS_W-1:0] pos_x_q;
  logic [POS_W-1:0] pos_y_q;
  logic             fwd_done;

  // Position moves on the same edge the FORWARD action retires, so it is visible with done.
  assign fwd_done = (state_q == FORWARD) && (cnt_q == '0);

  always_ff @(posedge clockc2 or posedge reset) begin
    if (reset) begin
      pos_x_q <= '0;
      pos_y_q <= '0;
    end else if (fwd_done) begin
      case (heading_q)
        2'd0:    pos_y_q <= pos_y_q + POS_ONE;
        2'd1:    pos_x_q <= pos_x_q + POS_ONE;
        2'd2:    pos_y_q <= pos_y_q - POS_ONE;
        default: pos_x_q <= pos_x_q - POS_ONE;
      endcase
    end
  end

  assign pos_x = pos_x_q;
  assign pos_y = pos_y_q;
`else
  assign pos_x = '0;
  assign pos_y = '0;
`endif

endmodule

// File: tb/tb_motor_command_executor.sv
// Bench for motor_command_executor: command table plus hand sequences, checked by a queue-based scoreboard monitor.
module tb_motor_command_executor;

  logic       clk;
  logic       rst;
  logic       avancar;
  logic       girar;
  logic       remover;
  logic       motor_esq;
  logic       motor_dir;
  logic       motor_dir_rev;
  logic       braco;
  logic       busy;
  logic       done;
  logic       erro;
  logic [1:0] heading;
  logic [7:0] pos_x;
  logic [7:0] pos_y;

  motor_command_executor #(
    .FWD_CYCLES(8),
    .TURN_CYCLES(12),
    .REMOVE_CYCLES(20),
    .CNT_W(8),
    .POS_W(8)
  ) dut (
    .clockc2(clk),
    .reset(rst),
    .avancar(avancar),
    .girar(girar),
    .remover(remover),
    .motor_esq(motor_esq),
    .motor_dir(motor_dir),
    .motor_dir_rev(motor_dir_rev),
    .braco(braco),
    .busy(busy),
    .done(done),
    .erro(erro),
    .heading(heading),
    .pos_x(pos_x),
    .pos_y(pos_y)
  );

  // Actuator pattern order: {motor_esq, motor_dir, motor_dir_rev, braco}
  localparam logic [3:0] P_FWD  = 4'b1100;
  localparam logic [3:0] P_TURN = 4'b1010;
  localparam logic [3:0] P_REM  = 4'b0001;

  typedef struct {
    logic       r;
    logic       g;
    logic       a;
    logic [3:0] pat;
    int         len;
    logic       err;
  } vec_t;

  typedef struct {
    logic [3:0] pat;
    int         len;
    logic       err;
    logic [1:0] head;
    logic [7:0] px;
    logic [7:0] py;
    logic       b2b;
  } exp_t;

  vec_t       tbl [10];
  exp_t       exp_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] head_m;
  logic [7:0] px_m;
  logic [7:0] py_m;

  int         cyc = 0;
  int         done_cyc = 0;
  int         mon_len = 0;
  logic       mon_active = 1'b0;
  logic [3:0] mon_pat = 4'b0;
  logic       mon_erro = 1'b0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1);
  end

  function automatic void chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, want, $time);
    end
  endfunction

  function automatic void push_exp(input logic [3:0] pat, input int len, input logic err,
                                   input logic b2b);
    if (pat == P_TURN) begin
      head_m = head_m + 2'd1;
    end else if (pat == P_FWD) begin
`ifdef ODOMETRY_EN
      case (head_m)
        2'd0:    py_m = py_m + 8'd1;
        2'd1:    px_m = px_m + 8'd1;
        2'd2:    py_m = py_m - 8'd1;
        default: px_m = px_m - 8'd1;
      endcase
`endif
    end
    exp_q.push_back('{pat, len, err, head_m, px_m, py_m, b2b});
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    chk("reached_idle", int'(exp_q.size() == 0 && busy == 1'b0), 1);
  endtask

  task automatic run_vec(input vec_t v);
    remover = v.r;
    girar   = v.g;
    avancar = v.a;
    push_exp(v.pat, v.len, v.err, 1'b0);
    tick();
    remover = 1'b0;
    girar   = 1'b0;
    avancar = 1'b0;
    wait_idle(100);
  endtask

  // Scoreboard monitor: measures each action and retires one expectation per done pulse.
  always @(negedge clk) begin
    logic [3:0] act;
    exp_t       e;
    cyc++;
    act = {motor_esq, motor_dir, motor_dir_rev, braco};
    if (rst) begin
      mon_active = 1'b0;
    end else begin
      if (act != 4'b0) begin
        if (!mon_active) begin
          mon_active = 1'b1;
          mon_len    = 0;
          mon_pat    = act;
          mon_erro   = erro;
          chk("start_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0 && exp_q[0].b2b) chk("step_gap", cyc - done_cyc, 1);
        end else begin
          chk("pat_stable", act, mon_pat);
        end
        chk("busy_active", busy, 1);
        mon_len++;
      end
      if (done) begin
        chk("done_expected", int'(mon_active && exp_q.size() > 0), 1);
        if (mon_active && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("pattern", mon_pat, e.pat);
          chk("duration", mon_len, e.len);
          chk("erro_pulse", mon_erro, e.err);
          chk("erro_cleared", erro, 0);
          chk("busy_done", busy, 0);
          chk("act_off_done", act, 0);
          chk("heading", heading, e.head);
          chk("pos_x", pos_x, e.px);
          chk("pos_y", pos_y, e.py);
        end
        mon_active = 1'b0;
        done_cyc   = cyc;
      end
    end
  end

  initial begin
    int n;
    rst     = 1'b0;
    avancar = 1'b0;
    girar   = 1'b0;
    remover = 1'b0;
    head_m  = 2'd0;
    px_m    = 8'd0;
    py_m    = 8'd0;

    tbl[0] = '{1'b0, 1'b0, 1'b1, P_FWD,  8,  1'b0};
    tbl[1] = '{1'b0, 1'b1, 1'b0, P_TURN, 12, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, P_TURN, 12, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b0, P_TURN, 12, 1'b0};
    tbl[4] = '{1'b0, 1'b1, 1'b0, P_TURN, 12, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 1'b1, P_REM,  20, 1'b1};
    tbl[6] = '{1'b0, 1'b1, 1'b1, P_TURN, 12, 1'b1};
    tbl[7] = '{1'b1, 1'b0, 1'b1, P_REM,  20, 1'b1};
    tbl[8] = '{1'b1, 1'b0, 1'b0, P_REM,  20, 1'b0};
    tbl[9] = '{1'b0, 1'b0, 1'b1, P_FWD,  8,  1'b0};

    #1 rst = 1'b1;
    #2;
    chk("reset_outputs", int'({motor_esq, motor_dir, motor_dir_rev, braco, busy, done, erro,
                               heading, pos_x, pos_y}), 0);
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("idle_after_reset", int'({motor_esq, motor_dir, motor_dir_rev, braco, busy, done,
                                  erro, heading}), 0);

    // Single forward step, four turns, multi-command collisions, removes, forward east.
    for (int i = 0; i < 10; i++) run_vec(tbl[i]);
    chk("heading_after_table", heading, head_m);

    // girar raised during FORWARD cycle 3 must be dropped.
    avancar = 1'b1;
    push_exp(P_FWD, 8, 1'b0, 1'b0);
    tick();
    avancar = 1'b0;
    tick();
    tick();
    girar = 1'b1;
    tick();
    girar = 1'b0;
    wait_idle(100);
    repeat (5) tick();
    chk("no_queued_turn", int'({busy, motor_dir_rev}), 0);
    chk("heading_unchanged", heading, head_m);

    // Async reset in TURN cycle 5: outputs clear before the next edge.
    girar = 1'b1;
    push_exp(P_TURN, 12, 1'b0, 1'b0);
    tick();
    girar = 1'b0;
    repeat (4) tick();
    chk("turn_active_c5", int'({motor_esq, motor_dir, motor_dir_rev, braco}), int'(P_TURN));
    #1 rst = 1'b1;
    exp_q.delete();
    head_m = 2'd0;
    px_m   = 8'd0;
    py_m   = 8'd0;
    #1;
    chk("async_reset_outputs", int'({motor_esq, motor_dir, motor_dir_rev, braco, busy, done,
                                     erro, pos_x, pos_y}), 0);
    chk("async_reset_heading", heading, 0);
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();
    chk("no_resume_after_reset", int'({motor_esq, motor_dir, motor_dir_rev, braco, busy,
                                       done}), 0);

    // Face west, step across x=0, then hold avancar for three steps.
    for (int i = 0; i < 3; i++) run_vec(tbl[1]);
    chk("heading_west", heading, 3);
    run_vec(tbl[0]);
    push_exp(P_FWD, 8, 1'b0, 1'b0);
    push_exp(P_FWD, 8, 1'b0, 1'b1);
    push_exp(P_FWD, 8, 1'b0, 1'b1);
    avancar = 1'b1;
    n = 0;
    while ((exp_q.size() > 1 || !motor_esq) && n < 200) begin
      tick();
      n++;
    end
    avancar = 1'b0;
    wait_idle(100);
    chk("pos_x_final", pos_x, px_m);
    chk("pos_y_final", pos_y, py_m);

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
